// File: rtl/xgemac_wb_stats.sv
// rtl/xgemac_wb_stats.sv - Wishbone statistics counters, pending/mask interrupt block for the XGE MAC
// Optional build macro XGEMAC_STATS_SATURATE_EN: counters saturate instead of wrapping.
module xgemac_wb_stats #(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_int_o,
    input  logic              evt_tx_frame_i,
    input  logic              evt_rx_frame_i,
    input  logic              evt_rx_crc_err_i,
    input  logic              evt_rx_ovf_i
);

    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ADDR_W-3:0] A_CTRL  = (ADDR_W-2)'(0);
    localparam logic [ADDR_W-3:0] A_PEND  = (ADDR_W-2)'(1);
    localparam logic [ADDR_W-3:0] A_MASK  = (ADDR_W-2)'(2);
    localparam logic [ADDR_W-3:0] A_TX    = (ADDR_W-2)'(4);
    localparam logic [ADDR_W-3:0] A_RX    = (ADDR_W-2)'(5);
    localparam logic [ADDR_W-3:0] A_CRC   = (ADDR_W-2)'(6);
    localparam logic [ADDR_W-3:0] A_OVF   = (ADDR_W-2)'(7);

    logic [CNT_W-1:0]  cnt     [4];
    logic [CNT_W-1:0]  cnt_nxt [4];
    logic [3:0]        evt;
    logic [3:0]        inc;
    logic [3:0]        hit;
    logic              en;
    logic [4:0]        pend;
    logic [4:0]        mask;
    logic [ADDR_W-3:0] word;
    logic              req;
    logic              wr;
    logic              clr;
    logic [31:0]       rd_data;
    logic              unused_bits;

    assign evt         = {evt_rx_ovf_i, evt_rx_crc_err_i, evt_rx_frame_i, evt_tx_frame_i};
    assign word        = wb_adr_i[ADDR_W-1:2];
    assign req         = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr          = req & wb_we_i;
    assign clr         = wr & (word == A_CTRL) & wb_dat_i[0];
    assign unused_bits = ^{wb_dat_i[31:5], wb_adr_i[1:0]};

    // hit marks the increment that produces the counter-event (max reached or wrap)
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inc[i] = en & evt[i];
`ifdef XGEMAC_STATS_SATURATE_EN
            cnt_nxt[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CNT_W'(1);
            hit[i]     = inc[i] & (cnt[i] != CNT_MAX) & (cnt_nxt[i] == CNT_MAX);
`else
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
            hit[i]     = inc[i] & (cnt[i] == CNT_MAX);
`endif
        end
    end

    always_comb begin
        rd_data = 32'h0;
        case (word)
            A_CTRL:  rd_data = {30'h0, en, 1'b0};
            A_PEND:  rd_data = {27'h0, pend};
            A_MASK:  rd_data = {27'h0, mask};
            A_TX:    rd_data = 32'(cnt[0]);
            A_RX:    rd_data = 32'(cnt[1]);
            A_CRC:   rd_data = 32'(cnt[2]);
            A_OVF:   rd_data = 32'(cnt[3]);
            default: rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'h0;
            wb_int_o <= 1'b0;
            en       <= 1'b1;
            pend     <= 5'h0;
            mask     <= 5'h0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            wb_ack_o <= req;
            wb_int_o <= |(pend & mask);
            if (req & ~wb_we_i) wb_dat_o <= rd_data;
            for (int i = 0; i < 4; i++) begin
                if (clr)         cnt[i] <= '0;
                else if (inc[i]) cnt[i] <= cnt_nxt[i];
            end
            if (wr && word == A_CTRL) en   <= wb_dat_i[1];
            if (wr && word == A_MASK) mask <= wb_dat_i[4:0];
            // new events override a same-cycle write-one-to-clear
            pend <= (pend & ~((wr && word == A_PEND) ? wb_dat_i[4:0] : 5'h0)) | {|hit, evt};
        end
    end

endmodule

// File: tb/tb_xgemac_wb_stats.sv
// tb/tb_xgemac_wb_stats.sv - randomized bench for xgemac_wb_stats against an arithmetic reference model
module tb_xgemac_wb_stats;

    localparam int CW   = 4;
    localparam int MAXV = (1 << CW) - 1;
`ifdef XGEMAC_STATS_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  adr = 8'h0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] dat_i = 32'h0;
    logic [31:0] dat_o;
    logic        ack, int_o;
    logic        tx = 1'b0, rx = 1'b0, crc = 1'b0, ovf = 1'b0;

    int total = 0;
    int bad   = 0;

    xgemac_wb_stats #(.CNT_W(CW), .ADDR_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_cyc_i(cyc),
        .wb_stb_i(stb), .wb_we_i(we), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_ack_o(ack), .wb_int_o(int_o),
        .evt_tx_frame_i(tx), .evt_rx_frame_i(rx),
        .evt_rx_crc_err_i(crc), .evt_rx_ovf_i(ovf)
    );

    always #5 clk = ~clk;

    // reference model state
    int        m_cnt [4];
    bit [4:0]  m_pend, m_mask;
    bit        m_en, m_ack, m_int;
    bit [31:0] m_dat;

    function automatic bit [31:0] model_read(input bit [7:0] a);
        case (a >> 2)
            0: return {30'h0, m_en, 1'b0};
            1: return {27'h0, m_pend};
            2: return {27'h0, m_mask};
            4, 5, 6, 7: return 32'(m_cnt[(a >> 2) - 4]);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack = 0; m_dat = 0; m_int = 0; m_en = 1; m_pend = 0; m_mask = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            bit        req, nint;
            bit [3:0]  ev;
            bit [4:0]  sets;
            bit [31:0] rd;
            req  = cyc && stb && !m_ack;
            rd   = model_read(adr);
            nint = (m_pend & m_mask) != 0;
            ev   = {ovf, crc, rx, tx};
            sets = {1'b0, ev};
            for (int i = 0; i < 4; i++) begin
                if (ev[i] && m_en) begin
                    if (SAT) begin
                        if (m_cnt[i] < MAXV) begin
                            m_cnt[i] = m_cnt[i] + 1;
                            if (m_cnt[i] == MAXV) sets[4] = 1;
                        end
                    end else begin
                        m_cnt[i] = (m_cnt[i] + 1) % (MAXV + 1);
                        if (m_cnt[i] == 0) sets[4] = 1;
                    end
                end
            end
            if (req && we) begin
                case (adr >> 2)
                    0: begin
                        if (dat_i[0]) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                        m_en = dat_i[1];
                    end
                    1: m_pend = m_pend & ~dat_i[4:0];
                    2: m_mask = dat_i[4:0];
                    default: ;
                endcase
            end
            m_pend = m_pend | sets;
            if (req && !we) m_dat = rd;
            m_ack = req;
            m_int = nint;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("ack", 32'(ack), 32'(m_ack));
        check("int", 32'(int_o), 32'(m_int));
        check("dat_o", dat_o, m_dat);
    end

    task automatic xfer(input bit w, input bit [7:0] a, input bit [31:0] d,
                        input bit [3:0] ev, output bit [31:0] rd);
        int n;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d;
        {ovf, crc, rx, tx} = ev;
        @(posedge clk); #1;
        {ovf, crc, rx, tx} = 4'h0;
        n = 0;
        while (!ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) check("ack_timeout", 32'(ack), 32'h1);
        rd = dat_o;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic rd_chk(input string name, input bit [7:0] a, input bit [31:0] exp);
        bit [31:0] v;
        xfer(1'b0, a, 32'h0, 4'h0, v);
        check(name, v, exp);
    endtask

    task automatic wr(input bit [7:0] a, input bit [31:0] d);
        bit [31:0] v;
        xfer(1'b1, a, d, 4'h0, v);
    endtask

    task automatic pulses(input bit [3:0] ev, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            {ovf, crc, rx, tx} = ev;
            @(posedge clk); #1;
            {ovf, crc, rx, tx} = 4'h0;
        end
    endtask

    initial begin
        bit [31:0] v;
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        rd_chk("rst_ctrl", 8'h00, 32'h2);
        rd_chk("rst_pend", 8'h04, 32'h0);
        rd_chk("rst_tx",   8'h10, 32'h0);

        // ack one cycle after request, alternate cycles while strobe held
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 8'h08;
        #3 check("ack_pre", 32'(ack), 32'h0);
        @(posedge clk); #1 check("ack_1st", 32'(ack), 32'h1);
        @(posedge clk); #1 check("ack_gap", 32'(ack), 32'h0);
        @(posedge clk); #1 check("ack_2nd", 32'(ack), 32'h1);
        cyc = 0; stb = 0;
        @(posedge clk); #1;

        // cycle abandoned before any sampling edge: no ack, no write
        cyc = 1; stb = 1; we = 1; adr = 8'h08; dat_i = 32'h1F;
        #3 cyc = 0; stb = 0; we = 0;
        repeat (3) begin
            @(posedge clk); #1 check("no_ack", 32'(ack), 32'h0);
        end
        rd_chk("no_write_mask", 8'h08, 32'h0);

        pulses(4'b0001, 5);
        rd_chk("tx_five", 8'h10, 32'h5);
        rd_chk("pend_tx", 8'h04, 32'h1);
        check("int_masked", 32'(int_o), 32'h0);
        wr(8'h08, 32'h1);
        @(posedge clk); #1 check("int_on", 32'(int_o), 32'h1);
        wr(8'h04, 32'h1);
        @(posedge clk); #1 check("int_off", 32'(int_o), 32'h0);

        wr(8'h04, 32'h1F);
        pulses(4'b0100, 15);
        rd_chk("pend_15crc", 8'h04, SAT ? 32'h14 : 32'h04);
        pulses(4'b0100, 1);
        rd_chk("crc_16", 8'h18, SAT ? 32'hF : 32'h0);
        xfer(1'b0, 8'h04, 32'h0, 4'h0, v);
        check("pend_cnt_evt", v & 32'h10, 32'h10);

        wr(8'h04, 32'h1F);
        pulses(4'b1000, 2);
        xfer(1'b1, 8'h00, 32'h3, 4'b1000, v);
        rd_chk("ovf_clr", 8'h1C, 32'h0);
        rd_chk("tx_clr",  8'h10, 32'h0);
        xfer(1'b0, 8'h04, 32'h0, 4'h0, v);
        check("pend_ovf", v & 32'h8, 32'h8);

        wr(8'h00, 32'h0);
        pulses(4'b0010, 3);
        rd_chk("rx_frozen", 8'h14, 32'h0);
        xfer(1'b0, 8'h04, 32'h0, 4'h0, v);
        check("pend_rx", v & 32'h2, 32'h2);
        rd_chk("unmapped", 8'h40, 32'h0);
        rd_chk("ctrl_dis", 8'h00, 32'h0);

        // reset while ack is high
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 8'h10;
        @(posedge clk); #1 check("ack_before_rst", 32'(ack), 32'h1);
        #1 rst = 1;
        #1 check("ack_rst_drop", 32'(ack), 32'h0);
        cyc = 0; stb = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        rd_chk("retry_ctrl", 8'h00, 32'h2);

        for (int it = 0; it < 500; it++) begin
            bit [7:0]  a;
            bit [31:0] d;
            int sel;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                {ovf, crc, rx, tx} = 4'($urandom) & 4'($urandom);
            end
            sel = $urandom_range(0, 9);
            case (sel)
                0: a = 8'h00;  1: a = 8'h04;  2: a = 8'h08;  3: a = 8'h10;
                4: a = 8'h14;  5: a = 8'h18;  6: a = 8'h1C;  7: a = 8'h0C;
                8: a = 8'h3D;  default: a = 8'($urandom);
            endcase
            d = $urandom;
            if (a == 8'h00) begin
                d[1] = ($urandom_range(0, 3) != 0);
                d[0] = ($urandom_range(0, 7) == 0);
            end
            xfer($urandom_range(0, 2) == 0, a, d, 4'($urandom) & 4'($urandom), v);
        end

        repeat (3) @(posedge clk);
        #1 $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
